// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared NCO types, width defaults and angle constants
// Purpose : state encoding and constants shared by the NCO front end and
//           the downstream CORDIC stage.
// Contents: nco_state_e (IDLE/RUN/SWEEP), width/latency defaults,
//           quarter-circle angle constants for the 16-bit angle format.
package nco_pkg;

   localparam int NCO_ACC_W      = 32;
   localparam int NCO_PHASE_W    = 16;
   localparam int NCO_CORDIC_LAT = 13;

   // Unsigned full-circle angle: 0x0000 = 0, 0x4000 = 90 deg, ...
   localparam logic [15:0] ANG_90  = 16'h4000;
   localparam logic [15:0] ANG_180 = 16'h8000;
   localparam logic [15:0] ANG_270 = 16'hC000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      SWEEP = 2'd2
   } nco_state_e;

endpackage

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - fixed-depth shift register for a valid flag
// Purpose : delays a valid flag by DEPTH clock cycles so it lines up with a
//           pipelined datapath. Only reset clears it; it never stalls.
// Ports   : clk     - clock, rising edge
//           rst     - asynchronous active-high reset
//           valid_i - flag to delay
//           valid_o - valid_i delayed DEPTH cycles
module valid_delay_line #(
   parameter int DEPTH = 13
) (
   input  logic clk,
   input  logic rst,
   input  logic valid_i,
   output logic valid_o
);

   logic [DEPTH-1:0] shift_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
      end else begin
         shift_q[0] <= valid_i;
         for (int i = 1; i < DEPTH; i++) begin
            shift_q[i] <= shift_q[i-1];
         end
      end
   end

   assign valid_o = shift_q[DEPTH-1];

endmodule

// File: rtl/nco_phase_gen.sv
// rtl/nco_phase_gen.sv - NCO phase accumulator with constant/chirp modes
// Purpose : generates the 16-bit angle stream for the CORDIC sin/cos stage,
//           either at constant frequency or with a linear FTW sweep that is
//           one-shot (then constant) or repeating.
// Ports   : clk, rst             - clock, async active-high reset
//           start / stop         - single-cycle commands (stop has priority)
//           ftw_start, ftw_step  - initial FTW and signed per-sample step
//           sweep_len            - sweep samples, 0 = constant frequency
//           sweep_repeat         - reload ftw_start after each sweep pass
//           phase_off            - constant angle offset
//           theta, theta_valid   - registered angle and its valid
//           sincos_valid         - theta_valid delayed CORDIC_LAT cycles
//           sweep_active         - state is SWEEP
//           sweep_done           - one-cycle pulse at end of each sweep pass
module nco_phase_gen
   import nco_pkg::*;
#(
   parameter int ACC_W      = NCO_ACC_W,
   parameter int PHASE_W    = NCO_PHASE_W,
   parameter int CORDIC_LAT = NCO_CORDIC_LAT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [ACC_W-1:0]   ftw_start,
   input  logic [ACC_W-1:0]   ftw_step,
   input  logic [15:0]        sweep_len,
   input  logic               sweep_repeat,
   input  logic [PHASE_W-1:0] phase_off,
   output logic [PHASE_W-1:0] theta,
   output logic               theta_valid,
   output logic               sincos_valid,
   output logic               sweep_active,
   output logic               sweep_done
);

   nco_state_e         state_q;
   logic [ACC_W-1:0]   acc_q;
   logic [ACC_W-1:0]   ftw_cur_q;
   logic [ACC_W-1:0]   ftw_start_q;
   logic [ACC_W-1:0]   ftw_step_q;
   logic [15:0]        sweep_len_q;
   logic [15:0]        cnt_q;
   logic               sweep_repeat_q;
   logic [PHASE_W-1:0] phase_off_q;
   logic [PHASE_W-1:0] theta_q;
   logic               theta_valid_q;
   logic               sweep_done_q;

   logic [PHASE_W-1:0] theta_d;
   logic [ACC_W-1:0]   acc_d;
   logic [ACC_W-1:0]   ftw_ramp_d;
   logic               sweep_end_d;

   always_comb begin
      theta_d     = acc_q[ACC_W-1 -: PHASE_W] + phase_off_q;
      acc_d       = acc_q + ftw_cur_q;
      ftw_ramp_d  = ftw_cur_q + ftw_step_q;
      sweep_end_d = (cnt_q == (sweep_len_q - 16'd1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         acc_q          <= '0;
         ftw_cur_q      <= '0;
         ftw_start_q    <= '0;
         ftw_step_q     <= '0;
         sweep_len_q    <= '0;
         cnt_q          <= '0;
         sweep_repeat_q <= 1'b0;
         phase_off_q    <= '0;
         theta_q        <= '0;
         theta_valid_q  <= 1'b0;
         sweep_done_q   <= 1'b0;
      end else if (stop) begin
         // theta holds its last value; only the accumulator is cleared.
         state_q       <= IDLE;
         acc_q         <= '0;
         theta_valid_q <= 1'b0;
         sweep_done_q  <= 1'b0;
      end else begin
         sweep_done_q <= 1'b0;
         case (state_q)
            RUN: begin
               theta_q       <= theta_d;
               theta_valid_q <= 1'b1;
               acc_q         <= acc_d;
            end
            SWEEP: begin
               theta_q       <= theta_d;
               theta_valid_q <= 1'b1;
               acc_q         <= acc_d;
               if (sweep_end_d) begin
                  sweep_done_q <= 1'b1;
                  cnt_q        <= '0;
                  if (sweep_repeat_q) begin
                     ftw_cur_q <= ftw_start_q;
                  end else begin
                     state_q <= RUN;
                  end
               end else begin
                  ftw_cur_q <= ftw_ramp_d;
                  cnt_q     <= cnt_q + 16'd1;
               end
            end
            default: begin
               theta_valid_q <= 1'b0;
            end
         endcase

         // A restart overrides the state update above but leaves the sample
         // just emitted on this edge intact, so a running stream has no gap.
         if (start) begin
            ftw_start_q    <= ftw_start;
            ftw_step_q     <= ftw_step;
            sweep_len_q    <= sweep_len;
            sweep_repeat_q <= sweep_repeat;
            phase_off_q    <= phase_off;
            acc_q          <= '0;
            ftw_cur_q      <= ftw_start;
            cnt_q          <= '0;
            sweep_done_q   <= 1'b0;
            state_q        <= (sweep_len != 16'd0) ? SWEEP : RUN;
         end
      end
   end

   valid_delay_line #(
      .DEPTH (CORDIC_LAT)
   ) u_sincos_delay (
      .clk     (clk),
      .rst     (rst),
      .valid_i (theta_valid_q),
      .valid_o (sincos_valid)
   );

   assign theta        = theta_q;
   assign theta_valid  = theta_valid_q;
   assign sweep_done   = sweep_done_q;
   assign sweep_active = (state_q == SWEEP);

endmodule

// File: tb/tb_nco_phase_gen.sv
// tb/tb_nco_phase_gen.sv - randomized self-checking bench for nco_phase_gen
module tb_nco_phase_gen;

   logic        clk;
   logic        rst;
   logic        start;
   logic        stop;
   logic [31:0] cfg_ftw;
   logic [31:0] cfg_step;
   logic [15:0] cfg_len;
   logic        cfg_rep;
   logic [15:0] cfg_off;
   logic [15:0] theta;
   logic        theta_valid;
   logic        sincos_valid;
   logic        sweep_active;
   logic        sweep_done;

   int n_tests = 0;
   int n_fail  = 0;

   nco_phase_gen dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .ftw_start    (cfg_ftw),
      .ftw_step     (cfg_step),
      .sweep_len    (cfg_len),
      .sweep_repeat (cfg_rep),
      .phase_off    (cfg_off),
      .theta        (theta),
      .theta_valid  (theta_valid),
      .sincos_valid (sincos_valid),
      .sweep_active (sweep_active),
      .sweep_done   (sweep_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: sample k of a started config is described in closed
   // form (FTW as a function of k), not as a cycle-level state machine.
   bit          m_run;
   int          m_k;
   logic [31:0] m_acc;
   logic [31:0] m_ftw0;
   logic [31:0] m_step;
   int          m_len;
   bit          m_rep;
   logic [15:0] m_off;

   logic [15:0] e_theta;
   bit          e_valid;
   bit          e_sincos;
   bit          e_active;
   bit          e_done;

   bit vhist [8192];
   int cyc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ftw_of(input int k);
      int idx;
      if (m_len == 0) return m_ftw0;
      if (m_rep) idx = k % m_len;
      else       idx = (k < m_len - 1) ? k : m_len - 1;
      return m_ftw0 + 32'(idx) * m_step;
   endfunction

   function automatic bit done_of(input int k);
      if (m_len == 0) return 1'b0;
      if (m_rep) return (k % m_len) == m_len - 1;
      return k == m_len - 1;
   endfunction

   task automatic model_edge(input bit s, input bit p);
      if (p) begin
         m_run    = 1'b0;
         e_valid  = 1'b0;
         e_done   = 1'b0;
         e_active = 1'b0;
      end else begin
         if (m_run) begin
            e_theta  = m_acc[31:16] + m_off;
            e_valid  = 1'b1;
            e_done   = done_of(m_k);
            e_active = (m_len != 0) && (m_rep || m_k < m_len - 1);
            m_acc    = m_acc + ftw_of(m_k);
            m_k++;
         end else begin
            e_valid  = 1'b0;
            e_done   = 1'b0;
            e_active = 1'b0;
         end
         if (s) begin
            m_ftw0   = cfg_ftw;
            m_step   = cfg_step;
            m_len    = int'(cfg_len);
            m_rep    = cfg_rep;
            m_off    = cfg_off;
            m_acc    = '0;
            m_k      = 0;
            m_run    = 1'b1;
            e_done   = 1'b0;
            e_active = (m_len != 0);
         end
      end
      vhist[cyc] = e_valid;
      e_sincos   = (cyc >= 13) ? vhist[cyc-13] : 1'b0;
      if (cyc < 8191) cyc++;
   endtask

   task automatic check_all(input string pfx);
      chk({pfx, "_theta"},  32'(theta),        32'(e_theta));
      chk({pfx, "_valid"},  32'(theta_valid),  32'(e_valid));
      chk({pfx, "_sincos"}, 32'(sincos_valid), 32'(e_sincos));
      chk({pfx, "_active"}, 32'(sweep_active), 32'(e_active));
      chk({pfx, "_done"},   32'(sweep_done),   32'(e_done));
   endtask

   task automatic step(input bit s, input bit p);
      start = s;
      stop  = p;
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      model_edge(s, p);
      check_all("model");
   endtask

   task automatic model_reset();
      m_run    = 1'b0;
      e_theta  = '0;
      e_valid  = 1'b0;
      e_sincos = 1'b0;
      e_active = 1'b0;
      e_done   = 1'b0;
      cyc      = 0;
      for (int i = 0; i < 8192; i++) vhist[i] = 1'b0;
   endtask

   task automatic set_cfg(input logic [31:0] f, input logic [31:0] st,
                          input logic [15:0] len, input bit rp, input logic [15:0] off);
      cfg_ftw  = f;
      cfg_step = st;
      cfg_len  = len;
      cfg_rep  = rp;
      cfg_off  = off;
   endtask

   logic [15:0] wrap_tbl  [5] = '{16'h2000, 16'h6000, 16'hA000, 16'hE000, 16'h2000};
   logic [15:0] shot_tbl  [7] = '{16'd0, 16'd0, 16'd1, 16'd3, 16'd6, 16'd9, 16'd12};
   logic [15:0] rep_tbl   [9] = '{16'd0, 16'd0, 16'd1, 16'd3, 16'd6, 16'd6, 16'd7, 16'd9, 16'd12};

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      set_cfg(32'h0, 32'h0, 16'd0, 1'b0, 16'h0);
      model_reset();
      #1;
      check_all("reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_all("reset_rel");

      // Constant frequency, no offset.
      set_cfg(32'h0100_0000, 32'h0, 16'd0, 1'b0, 16'h0);
      step(1'b1, 1'b0);
      chk("c1_first_valid", 32'(theta_valid), 32'd0);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0);
         chk("c1_theta", 32'(theta), 32'(i * 32'h100));
         chk("c1_active", 32'(sweep_active), 32'd0);
         if (i == 12 || i == 13) chk("c1_sincos_edge", 32'(sincos_valid), (i == 13) ? 32'd1 : 32'd0);
      end
      step(1'b0, 1'b1);
      repeat (15) step(1'b0, 1'b0);

      // Wrap with offset.
      set_cfg(32'h4000_0000, 32'h0, 16'd0, 1'b0, 16'h2000);
      step(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0);
         chk("wrap_theta", 32'(theta), 32'(wrap_tbl[i]));
      end
      step(1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0);

      // One-shot sweep.
      set_cfg(32'h0, 32'h0001_0000, 16'd4, 1'b0, 16'h0);
      step(1'b1, 1'b0);
      chk("shot_active_start", 32'(sweep_active), 32'd1);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b0);
         chk("shot_theta",  32'(theta),        32'(shot_tbl[i]));
         chk("shot_done",   32'(sweep_done),   (i == 3) ? 32'd1 : 32'd0);
         chk("shot_active", 32'(sweep_active), (i < 3)  ? 32'd1 : 32'd0);
      end

      // Repeating sweep, issued as a restart while running.
      cfg_rep = 1'b1;
      step(1'b1, 1'b0);
      for (int i = 0; i < 9; i++) begin
         step(1'b0, 1'b0);
         chk("rep_theta",  32'(theta),        32'(rep_tbl[i]));
         chk("rep_done",   32'(sweep_done),   ((i % 4) == 3) ? 32'd1 : 32'd0);
         chk("rep_active", 32'(sweep_active), 32'd1);
      end
      step(1'b0, 1'b1);
      repeat (15) step(1'b0, 1'b0);

      // Start and stop together during RUN: stop wins, pipeline flushes.
      set_cfg(32'h0123_4567, 32'h0, 16'd0, 1'b0, 16'h0010);
      step(1'b1, 1'b0);
      repeat (20) step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      chk("ss_valid", 32'(theta_valid), 32'd0);
      chk("ss_sincos_hold", 32'(sincos_valid), 32'd1);
      for (int j = 1; j <= 14; j++) begin
         step(1'b0, 1'b0);
         chk("ss_sincos", 32'(sincos_valid), (j < 13) ? 32'd1 : 32'd0);
      end

      // Asynchronous reset mid-sweep.
      set_cfg(32'h0800_0000, 32'h0010_0000, 16'd5, 1'b1, 16'h0404);
      step(1'b1, 1'b0);
      repeat (16) step(1'b0, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_theta",  32'(theta),        32'd0);
      chk("rst_valid",  32'(theta_valid),  32'd0);
      chk("rst_sincos", 32'(sincos_valid), 32'd0);
      chk("rst_active", 32'(sweep_active), 32'd0);
      chk("rst_done",   32'(sweep_done),   32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) step(1'b0, 1'b0);
      set_cfg(32'h0001_0000, 32'h0, 16'd0, 1'b0, 16'h1234);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      chk("rst_first_theta", 32'(theta), 32'h1234);
      chk("rst_first_valid", 32'(theta_valid), 32'd1);
      step(1'b0, 1'b1);
      repeat (2) step(1'b0, 1'b0);

      // Randomized episodes: random config, idle-inputs churn, restarts.
      for (int ep = 0; ep < 30; ep++) begin
         set_cfg($urandom, $urandom,
                 ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 7)),
                 1'($urandom_range(0, 1)), 16'($urandom));
         step(1'b1, 1'b0);
         for (int i = 0; i < int'($urandom_range(5, 25)); i++) begin
            if ($urandom_range(0, 3) == 0) begin
               set_cfg($urandom, $urandom, 16'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 16'($urandom));
            end
            step(($urandom_range(0, 19) == 0), 1'b0);
         end
         step(1'b0, 1'b1);
         repeat ($urandom_range(0, 15)) step(1'b0, 1'b0);
      end
      repeat (15) step(1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
